// File: rtl/accel_mem_arbiter_pkg.sv
// Shared types for the accelerator RAM port-A arbiter: priority modes and requester ids.
package cfg_types_pkg;

  typedef enum logic [1:0] {
    ARB_RR       = 2'd0,
    ARB_ACC_PRIO = 2'd1,
    ARB_BUS_PRIO = 2'd2,
    ARB_RSVD     = 2'd3
  } arb_mode_t;

  typedef enum logic {
    REQ_BUS = 1'b0,
    REQ_ACC = 1'b1
  } req_id_t;

  localparam int unsigned CONFLICT_CNT_W = 16;
  localparam int unsigned WAIT_CNT_W     = 4;

  function automatic req_id_t other_req(input req_id_t id);
    return (id == REQ_BUS) ? REQ_ACC : REQ_BUS;
  endfunction

endpackage

// File: rtl/accel_mem_arbiter_if.sv
// Bundle of requester, RAM port-A and status signals around the port-A arbiter.
interface accel_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  cfg_types_pkg::arb_mode_t mode;

  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [BE_WIDTH-1:0]   bus_be;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_gnt;
  logic                  bus_rvalid;
  logic [DATA_WIDTH-1:0] bus_rdata;

  logic                  acc_req;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [BE_WIDTH-1:0]   acc_be;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic                  acc_gnt;
  logic                  acc_rvalid;
  logic [DATA_WIDTH-1:0] acc_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [BE_WIDTH-1:0]   mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic [15:0]           conflict_cnt;

  modport slave (
    input  mode,
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  acc_req, acc_we, acc_addr, acc_be, acc_wdata,
    input  mem_rdata,
    output bus_gnt, bus_rvalid, bus_rdata,
    output acc_gnt, acc_rvalid, acc_rdata,
    output mem_en, mem_we, mem_addr, mem_be, mem_wdata,
    output conflict_cnt
  );

  modport master (
    output mode,
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output acc_req, acc_we, acc_addr, acc_be, acc_wdata,
    output mem_rdata,
    input  bus_gnt, bus_rvalid, bus_rdata,
    input  acc_gnt, acc_rvalid, acc_rdata,
    input  mem_en, mem_we, mem_addr, mem_be, mem_wdata,
    input  conflict_cnt
  );
endinterface

// File: rtl/accel_mem_arbiter_wait_cnt.sv
// Per-requester wait counter; saturates at MAX_WAIT and flags starvation.
module arb_wait_cnt
  import cfg_types_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic starved
);

  localparam logic [WAIT_CNT_W-1:0] MAX_W = WAIT_CNT_W'(MAX_WAIT);

  logic [WAIT_CNT_W-1:0] r_cnt;

  // Count denied cycles; any grant or dropped request restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
    end else if (!req || gnt) begin
      r_cnt <= 4'd0;
    end else if (r_cnt != MAX_W) begin
      r_cnt <= r_cnt + 4'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign starved = (r_cnt == MAX_W);

endmodule

// File: rtl/accel_mem_arbiter.sv
// RAM port-A arbiter between the bus slave and accelerator port B, with starvation
// guard, one-cycle response routing and a saturating contention counter.
module accel_mem_arbiter
  import cfg_types_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  accel_mem_arbiter_if.slave arb
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                      w_contention;
  logic                      w_bus_starved;
  logic                      w_acc_starved;
  logic                      w_bus_gnt;
  logic                      w_acc_gnt;
  logic                      w_any_gnt;
  req_id_t                   w_winner;
  logic                      w_mem_we;
  logic [ADDR_WIDTH-1:0]     w_mem_addr;
  logic [BE_WIDTH-1:0]       w_mem_be;
  logic [DATA_WIDTH-1:0]     w_mem_wdata;
  logic                      w_bus_rvalid;
  logic                      w_acc_rvalid;

  req_id_t                   r_last_winner;
  req_id_t                   r_rsp_owner;
  logic                      r_rsp_pending;
  logic [CONFLICT_CNT_W-1:0] r_conflict_cnt;

  arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_bus_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb.bus_req),
    .gnt     (w_bus_gnt),
    .starved (w_bus_starved)
  );

  arb_wait_cnt #(.MAX_WAIT(MAX_WAIT)) u_acc_wait (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb.acc_req),
    .gnt     (w_acc_gnt),
    .starved (w_acc_starved)
  );

  assign w_contention = arb.bus_req & arb.acc_req;
  assign w_any_gnt    = w_bus_gnt | w_acc_gnt;

  // Grant decision: starvation first, then the mode; reserved mode falls back to round-robin.
  always_comb begin
    w_winner  = r_last_winner;
    w_bus_gnt = 1'b0;
    w_acc_gnt = 1'b0;
    if (w_contention) begin
      if (w_bus_starved && w_acc_starved) begin
        w_winner = other_req(r_last_winner);
      end else if (w_bus_starved) begin
        w_winner = REQ_BUS;
      end else if (w_acc_starved) begin
        w_winner = REQ_ACC;
      end else begin
        case (arb.mode)
          ARB_ACC_PRIO: w_winner = REQ_ACC;
          ARB_BUS_PRIO: w_winner = REQ_BUS;
          default:      w_winner = other_req(r_last_winner);
        endcase
      end
      w_bus_gnt = (w_winner == REQ_BUS);
      w_acc_gnt = (w_winner == REQ_ACC);
    end else if (arb.bus_req) begin
      w_winner  = REQ_BUS;
      w_bus_gnt = 1'b1;
    end else if (arb.acc_req) begin
      w_winner  = REQ_ACC;
      w_acc_gnt = 1'b1;
    end else begin
      w_winner  = r_last_winner;
    end
  end

  // Port-A request mux; all fields are forced to zero without a grant.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = '0;
    w_mem_be    = '0;
    w_mem_wdata = '0;
    if (w_bus_gnt) begin
      w_mem_we    = arb.bus_we;
      w_mem_addr  = arb.bus_addr;
      w_mem_be    = arb.bus_be;
      w_mem_wdata = arb.bus_wdata;
    end else if (w_acc_gnt) begin
      w_mem_we    = arb.acc_we;
      w_mem_addr  = arb.acc_addr;
      w_mem_be    = arb.acc_be;
      w_mem_wdata = arb.acc_wdata;
    end else begin
      w_mem_we    = 1'b0;
    end
  end

  // Winner history and response ownership, refreshed on every grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_winner <= REQ_ACC;
      r_rsp_owner   <= REQ_BUS;
      r_rsp_pending <= 1'b0;
    end else if (w_any_gnt) begin
      r_last_winner <= w_winner;
      r_rsp_owner   <= w_winner;
      r_rsp_pending <= 1'b1;
    end else begin
      r_last_winner <= r_last_winner;
      r_rsp_owner   <= r_rsp_owner;
      r_rsp_pending <= 1'b0;
    end
  end

  // Saturating count of cycles in which both requesters competed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= 16'd0;
    end else if (w_contention && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end else begin
      r_conflict_cnt <= r_conflict_cnt;
    end
  end

  assign w_bus_rvalid = r_rsp_pending & (r_rsp_owner == REQ_BUS);
  assign w_acc_rvalid = r_rsp_pending & (r_rsp_owner == REQ_ACC);

  assign arb.bus_gnt      = w_bus_gnt;
  assign arb.acc_gnt      = w_acc_gnt;
  assign arb.bus_rvalid   = w_bus_rvalid;
  assign arb.acc_rvalid   = w_acc_rvalid;
  assign arb.bus_rdata    = w_bus_rvalid ? arb.mem_rdata : '0;
  assign arb.acc_rdata    = w_acc_rvalid ? arb.mem_rdata : '0;
  assign arb.mem_en       = w_any_gnt;
  assign arb.mem_we       = w_mem_we;
  assign arb.mem_addr     = w_mem_addr;
  assign arb.mem_be       = w_mem_be;
  assign arb.mem_wdata    = w_mem_wdata;
  assign arb.conflict_cnt = r_conflict_cnt;

endmodule
